// File: rtl/alu_sched.sv
// alu_sched: shares one registered ALU between two requesters.
//
// Round-robin arbitration in IDLE, operands/opcode held on the ALU inputs
// while the ALU settles, result and flags captured into a tagged response
// that is returned over a valid/ready handshake.
//
// Ports:
//   clk, reset                  clock (rising edge), async active-low reset
//   reqN_valid/ready            requester N handshake (ready is combinational)
//   reqN_opcode, reqN_a/b       requester N operation
//   alu_a, alu_b, alu_opcode    registered operands/opcode to the ALU
//   alu_result, alu_carryout,
//   alu_overflow, alu_zero      ALU outputs
//   rsp_valid/ready             response handshake
//   rsp_id                      requester that issued the operation
//   rsp_result, rsp_carryout,
//   rsp_overflow, rsp_zero      captured ALU outputs
//   busy                        high whenever the scheduler is not idle
module alu_sched #(
  parameter int unsigned NUMBITS = 8,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [2:0]         req0_opcode,
  input  logic [NUMBITS-1:0] req0_a,
  input  logic [NUMBITS-1:0] req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [2:0]         req1_opcode,
  input  logic [NUMBITS-1:0] req1_a,
  input  logic [NUMBITS-1:0] req1_b,
  output logic [NUMBITS-1:0] alu_a,
  output logic [NUMBITS-1:0] alu_b,
  output logic [2:0]         alu_opcode,
  input  logic [NUMBITS-1:0] alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [NUMBITS-1:0] rsp_result,
  output logic               rsp_carryout,
  output logic               rsp_overflow,
  output logic               rsp_zero,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [NUMBITS-1:0] a;
    logic [NUMBITS-1:0] b;
  } req_t;

  state_t             state;
  logic               last_grant;
  logic               id;
  logic [CNT_W-1:0]   cnt;

  req_t               req0;
  req_t               req1;
  req_t               sel;
  logic               grant1;
  logic               accept;

  assign req0 = {req0_opcode, req0_a, req0_b};
  assign req1 = {req1_opcode, req1_a, req1_b};

  // Round-robin: on a tie the requester not granted last time wins.
  always_comb begin
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant1 = ~last_grant;
    end else begin
      grant1 = req1_valid;
    end
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant1;
  assign req1_ready = (state == IDLE) && req1_valid && grant1;
  assign accept     = req0_ready || req1_ready;
  assign sel        = grant1 ? req1 : req0;

  // Scheduler FSM with all datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      id           <= 1'b0;
      cnt          <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= 3'b000;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_carryout <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a      <= sel.a;
            alu_b      <= sel.b;
            alu_opcode <= sel.opcode;
            id         <= grant1;
            last_grant <= grant1;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          // Operands have been on the ALU for ALU_LAT+1 edges when cnt tops out.
          if (cnt != CNT_W'(ALU_LAT)) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            rsp_result   <= alu_result;
            rsp_carryout <= alu_carryout;
            rsp_overflow <= alu_overflow;
            rsp_zero     <= alu_zero;
            rsp_id       <= id;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Testbench for alu_sched: ALU_LAT=1 instance driven by directed and random
// operations, plus an ALU_LAT=3 instance for the longer-latency case.
module tb_alu_sched;

  localparam int W     = 8;
  localparam int LAT   = 1;
  localparam int MAXU  = (1 << W) - 1;
  localparam int SMAX  = (1 << (W - 1)) - 1;
  localparam int SMIN  = -(1 << (W - 1));

  typedef struct packed {
    logic         c;
    logic         ov;
    logic         z;
    logic [W-1:0] r;
  } alu_out_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ALU_LAT=1 instance signals
  logic         r0v, r1v, r0rdy, r1rdy;
  logic [2:0]   r0op, r1op, alu_op;
  logic [W-1:0] r0a, r0b, r1a, r1b, alu_a, alu_b, alu_res, rsp_res;
  logic         alu_c, alu_ov, alu_z;
  logic         rsp_valid, rsp_rdy, rsp_id, rsp_c, rsp_ov, rsp_z, busy;

  // ALU_LAT=3 instance signals
  logic         l3_r0v, l3_r1v, l3_r0rdy, l3_r1rdy;
  logic [2:0]   l3_r0op, l3_r1op, l3_alu_op;
  logic [W-1:0] l3_r0a, l3_r0b, l3_r1a, l3_r1b, l3_alu_a, l3_alu_b, l3_alu_res, l3_rsp_res;
  logic         l3_alu_c, l3_alu_ov, l3_alu_z;
  logic         l3_rsp_valid, l3_rsp_rdy, l3_rsp_id, l3_rsp_c, l3_rsp_ov, l3_rsp_z, l3_busy;

  int checks = 0;
  int errors = 0;
  int m_last = 1;

  // Reference ALU behaviour from plain integer arithmetic.
  function automatic alu_out_t alu_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int ua, ub, sa, sb, s;
    alu_out_t o;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    o  = '0;
    case (op)
      3'b000: begin s = ua + ub; o.r = W'(s); o.c = (s > MAXU); o.ov = o.c; end
      3'b001: begin s = sa + sb; o.r = W'(s); o.c = ((ua + ub) > MAXU); o.ov = (s > SMAX) || (s < SMIN); end
      3'b010: begin s = ua - ub; o.r = W'(s); o.c = (ua < ub); o.ov = o.c; end
      3'b011: begin s = sa - sb; o.r = W'(s); o.c = (ua < ub); o.ov = (s > SMAX) || (s < SMIN); end
      3'b100: o.r = a & b;
      3'b101: o.r = a | b;
      3'b110: o.r = a ^ b;
      default: o.r = a >> 1;
    endcase
    o.z = (o.r == '0);
    return o;
  endfunction

  // Registered ALU models with the matching latency.
  alu_out_t p1;
  alu_out_t p3 [3];
  always @(posedge clk) p1 <= alu_ref(alu_op, alu_a, alu_b);
  always @(posedge clk) begin
    p3[0] <= alu_ref(l3_alu_op, l3_alu_a, l3_alu_b);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign alu_res = p1.r;
  assign alu_c   = p1.c;
  assign alu_ov  = p1.ov;
  assign alu_z   = p1.z;
  assign l3_alu_res = p3[2].r;
  assign l3_alu_c   = p3[2].c;
  assign l3_alu_ov  = p3[2].ov;
  assign l3_alu_z   = p3[2].z;

  alu_sched #(.NUMBITS(W), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_opcode(r0op), .req0_a(r0a), .req0_b(r0b),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_opcode(r1op), .req1_a(r1a), .req1_b(r1b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_op),
    .alu_result(alu_res), .alu_carryout(alu_c), .alu_overflow(alu_ov), .alu_zero(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_rdy), .rsp_id(rsp_id), .rsp_result(rsp_res),
    .rsp_carryout(rsp_c), .rsp_overflow(rsp_ov), .rsp_zero(rsp_z), .busy(busy)
  );

  alu_sched #(.NUMBITS(W), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(l3_r0v), .req0_ready(l3_r0rdy), .req0_opcode(l3_r0op), .req0_a(l3_r0a), .req0_b(l3_r0b),
    .req1_valid(l3_r1v), .req1_ready(l3_r1rdy), .req1_opcode(l3_r1op), .req1_a(l3_r1a), .req1_b(l3_r1b),
    .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_opcode(l3_alu_op),
    .alu_result(l3_alu_res), .alu_carryout(l3_alu_c), .alu_overflow(l3_alu_ov), .alu_zero(l3_alu_z),
    .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_rdy), .rsp_id(l3_rsp_id), .rsp_result(l3_rsp_res),
    .rsp_carryout(l3_rsp_c), .rsp_overflow(l3_rsp_ov), .rsp_zero(l3_rsp_z), .busy(l3_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete operation on the ALU_LAT=1 instance; entered at a negedge with the DUT idle.
  task automatic do_op(input logic v0, input logic v1,
                       input logic [2:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [2:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input int bp);
    int gid, lat;
    alu_out_t e;
    logic [2:0] eop;
    logic [W-1:0] ea, eb;
    gid = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v1 ? 1 : 0);
    eop = (gid == 1) ? op1 : op0;
    ea  = (gid == 1) ? a1 : a0;
    eb  = (gid == 1) ? b1 : b0;
    e   = alu_ref(eop, ea, eb);
    r0v = v0; r0op = op0; r0a = a0; r0b = b0;
    r1v = v1; r1op = op1; r1a = a1; r1b = b1;
    #1;
    chk("req0_ready", 32'(r0rdy), 32'(gid == 0));
    chk("req1_ready", 32'(r1rdy), 32'(gid == 1));
    @(posedge clk); #1;
    m_last = gid;
    // Requester inputs change freely once accepted.
    r0a = W'($urandom); r0b = W'($urandom); r0op = 3'($urandom); r0v = 1'($urandom);
    r1a = W'($urandom); r1b = W'($urandom); r1op = 3'($urandom); r1v = 1'($urandom);
    chk("busy_after_accept", 32'(busy), 32'(1));
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      chk("alu_in_hold_wait", 32'({alu_op, alu_a, alu_b}), 32'({eop, ea, eb}));
      chk("readys_low_wait", 32'({r1rdy, r0rdy}), 32'(0));
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_latency", 32'(lat), 32'(LAT + 1));
    chk("rsp_id", 32'(rsp_id), 32'(gid));
    chk("rsp_result", 32'(rsp_res), 32'(e.r));
    chk("rsp_flags", 32'({rsp_c, rsp_ov, rsp_z}), 32'({e.c, e.ov, e.z}));
    for (int k = 0; k < bp; k++) begin
      r0v = 1'b1; r1v = 1'b1;
      @(posedge clk); #1;
      chk("bp_rsp_stable", 32'({rsp_valid, rsp_id, rsp_c, rsp_ov, rsp_z, rsp_res}),
          32'({1'b1, 1'(gid), e.c, e.ov, e.z, e.r}));
      chk("bp_readys_low", 32'({r1rdy, r0rdy}), 32'(0));
      chk("bp_busy", 32'(busy), 32'(1));
      chk("alu_in_hold_resp", 32'({alu_op, alu_a, alu_b}), 32'({eop, ea, eb}));
    end
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    r0v = 1'b0; r1v = 1'b0;
    chk("rsp_valid_cleared", 32'(rsp_valid), 32'(0));
    chk("busy_cleared", 32'(busy), 32'(0));
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic v0, v1;
    reset = 1'b0;
    r0v = 0; r1v = 0; r0op = 0; r1op = 0; r0a = 0; r0b = 0; r1a = 0; r1b = 0; rsp_rdy = 0;
    l3_r0v = 0; l3_r1v = 0; l3_r0op = 0; l3_r1op = 0;
    l3_r0a = 0; l3_r0b = 0; l3_r1a = 0; l3_r1b = 0; l3_rsp_rdy = 0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_alu_in", 32'({alu_op, alu_a, alu_b}), 32'(0));
    chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_c, rsp_ov, rsp_z, rsp_res}), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_l3", 32'({l3_rsp_valid, l3_busy, l3_alu_a}), 32'(0));
    reset = 1'b1;
    @(negedge clk);

    // Tie out of reset, then alternating grants
    do_op(1, 1, 3'b001, 8'h65, 8'h39, 3'b011, 8'h88, 8'h4A, 0);
    do_op(1, 1, 3'b001, 8'h65, 8'h39, 3'b011, 8'h88, 8'h4A, 0);
    do_op(1, 1, 3'b000, 8'h12, 8'h34, 3'b010, 8'h10, 8'h20, 0);
    do_op(1, 1, 3'b101, 8'hF0, 8'h0F, 3'b110, 8'h3C, 8'h3C, 0);
    // Single op with carry and zero
    do_op(1, 0, 3'b000, 8'hFF, 8'h01, 3'b000, 8'h00, 8'h00, 0);
    // Backpressure with the other requester pending
    do_op(0, 1, 3'b011, 8'h7F, 8'h80, 3'b000, 8'h00, 8'h00, 0);
    do_op(1, 0, 3'b010, 8'h05, 8'h09, 3'b000, 8'h00, 8'h00, 5);
    do_op(0, 1, 3'b000, 8'h00, 8'h00, 3'b001, 8'h7F, 8'h01, 0);
    // Operand hold
    do_op(1, 0, 3'b100, 8'hCA, 8'hAC, 3'b000, 8'h00, 8'h00, 2);

    // Reset mid-WAIT drops the operation
    r0v = 1'b1; r0op = 3'b101; r0a = 8'h33; r0b = 8'h44;
    @(posedge clk); #1;
    r0v = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    m_last = 1;
    chk("midrst_alu_a", 32'(alu_a), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", 32'(rsp_valid), 32'(0));
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_op(1, 1, 3'b111, 8'h5C, 8'h77, 3'b000, 8'h01, 8'h02, 0);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      do_op(v0, v1, 3'($urandom), W'($urandom), W'($urandom),
            3'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
    end

    // ALU_LAT=3 instance
    l3_r0v = 1'b1; l3_r0op = 3'b110; l3_r0a = 8'hAA; l3_r0b = 8'hFF;
    #1;
    chk("l3_ready0", 32'(l3_r0rdy), 32'(1));
    @(posedge clk); #1;
    l3_r0v = 1'b0; l3_r0a = 8'h00;
    lat = 0;
    while (l3_rsp_valid !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("l3_latency", 32'(lat), 32'(4));
    chk("l3_result", 32'(l3_rsp_res), 32'(8'h55));
    chk("l3_flags", 32'({l3_rsp_c, l3_rsp_ov, l3_rsp_z}), 32'(0));
    chk("l3_id", 32'(l3_rsp_id), 32'(0));
    l3_rsp_rdy = 1'b1;
    @(posedge clk); #1;
    l3_rsp_rdy = 1'b0;
    chk("l3_rsp_cleared", 32'({l3_rsp_valid, l3_busy}), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
